// File: rtl/pll_lock_reset_ctrl.sv
// rtl/pll_lock_reset_ctrl.sv - PLL lock supervisor and system reset sequencer
module pll_lock_reset_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 270000,
    parameter int PLL_RST_CYCLES = 32,
    parameter int GLITCH_CYCLES  = 4,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_in,
    input  logic       clr_cnt,
    output logic       pll_rst_out,
    output logic       sys_rst_out,
    output logic       ready,
    output logic [7:0] loss_cnt,
    output logic [7:0] retry_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] C_PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0]    C_GLITCH_LAST  = GW'(GLITCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [GW-1:0]          r_gcnt;
    logic                   r_pll_rst;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic [7:0]             r_loss;
    logic [7:0]             r_retry;

    logic w_lock_s;
    logic w_retry_evt;
    logic w_loss_evt;

    assign w_lock_s    = r_sync[SYNC_STAGES-1];
    assign w_retry_evt = (r_state == S_WAIT) && !w_lock_s && (r_cnt == C_TIMEOUT_LAST);
    assign w_loss_evt  = (r_state == S_RUN) && !w_lock_s && (r_gcnt == C_GLITCH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], lock_in};
        end
    end

    // Outputs are written alongside each transition so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_PLLRST;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_PLLRST: begin
                    if (r_cnt == C_PLL_LAST) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (w_retry_evt) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_STABLE_LAST) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_gcnt    <= '0;
                        r_sys_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_lock_s) begin
                        r_gcnt <= '0;
                    end else if (w_loss_evt) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= '0;
                        r_gcnt    <= '0;
                        r_pll_rst <= 1'b1;
                        r_sys_rst <= 1'b1;
                        r_ready   <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_PLLRST;
                    r_cnt     <= '0;
                    r_gcnt    <= '0;
                    r_pll_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // A clear request beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loss  <= '0;
            r_retry <= '0;
        end else begin
            if (clr_cnt) begin
                r_loss <= '0;
            end else if (w_loss_evt && (r_loss != 8'hFF)) begin
                r_loss <= r_loss + 1'b1;
            end
            if (clr_cnt) begin
                r_retry <= '0;
            end else if (w_retry_evt && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 1'b1;
            end
        end
    end

    assign pll_rst_out = r_pll_rst;
    assign sys_rst_out = r_sys_rst;
    assign ready       = r_ready;
    assign loss_cnt    = r_loss;
    assign retry_cnt   = r_retry;
    assign state       = r_state;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb/tb_pll_lock_reset_ctrl.sv - self-checking bench for pll_lock_reset_ctrl
module tb_pll_lock_reset_ctrl;

    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 100;
    localparam int PLLRST  = 8;
    localparam int GLITCH  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock_in;
    logic       clr_cnt;
    logic       pll_rst_out;
    logic       sys_rst_out;
    logic       ready;
    logic [7:0] loss_cnt;
    logic [7:0] retry_cnt;
    logic [1:0] state;

    pll_lock_reset_ctrl #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .PLL_RST_CYCLES(PLLRST),
        .GLITCH_CYCLES (GLITCH),
        .CNT_W         (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock_in    (lock_in),
        .clr_cnt    (clr_cnt),
        .pll_rst_out(pll_rst_out),
        .sys_rst_out(sys_rst_out),
        .ready      (ready),
        .loss_cnt   (loss_cnt),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic s_rst, s_lock, s_clr;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        s_rst  <= rst;
        s_lock <= lock_in;
        s_clr  <= clr_cnt;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each phase has an absolute end time; loss of lock is a run of low samples.
    int  m_phase, m_deadline, m_low, m_loss, m_retry;
    bit  m_sync [SYNC];
    bit  m_valid = 1'b0;

    task automatic m_enter(input int p);
        m_phase = p;
        m_low   = 0;
        case (p)
            0:       m_deadline = cyc + PLLRST;
            1:       m_deadline = cyc + TIMEOUT;
            2:       m_deadline = cyc + STABLE;
            default: m_deadline = cyc;
        endcase
    endtask

    task automatic model_step();
        bit ls;
        bit inc_l, inc_r;
        if (s_rst) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_enter(0);
            m_loss  = 0;
            m_retry = 0;
        end else begin
            ls = m_sync[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = s_lock;
            inc_l = 1'b0;
            inc_r = 1'b0;
            case (m_phase)
                0: if (cyc == m_deadline) m_enter(1);
                1: begin
                    if (ls) m_enter(2);
                    else if (cyc == m_deadline) begin
                        m_enter(0);
                        inc_r = 1'b1;
                    end
                end
                2: begin
                    if (!ls) m_enter(1);
                    else if (cyc == m_deadline) m_enter(3);
                end
                default: begin
                    m_low = ls ? 0 : m_low + 1;
                    if (m_low == GLITCH) begin
                        m_enter(0);
                        inc_l = 1'b1;
                    end
                end
            endcase
            if (inc_l && m_loss < 255) m_loss++;
            if (inc_r && m_retry < 255) m_retry++;
            if (s_clr) begin
                m_loss  = 0;
                m_retry = 0;
            end
        end
        m_valid = 1'b1;
    endtask

    logic [20:0] exp_v, act_v;
    initial forever begin
        @(negedge clk);
        model_step();
        if (m_valid) begin
            exp_v = {m_phase == 0, m_phase != 3, m_phase == 3, 2'(m_phase), 8'(m_loss), 8'(m_retry)};
            act_v = {pll_rst_out, sys_rst_out, ready, state, loss_cnt, retry_cnt};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cmp cycle %0d: got pll=%b sys=%b rdy=%b st=%0d loss=%0d retry=%0d, expected pll=%b sys=%b rdy=%b st=%0d loss=%0d retry=%0d",
                         cyc, act_v[20], act_v[19], act_v[18], act_v[17:16], act_v[15:8], act_v[7:0],
                         exp_v[20], exp_v[19], exp_v[18], exp_v[17:16], exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    task automatic wait_state(input logic [1:0] s, input int bound, output int t);
        int k;
        k = 0;
        while (state !== s && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (state !== s) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_state_%0d: not reached within %0d cycles", s, bound);
            t = -1;
        end else begin
            t = cyc;
        end
    endtask

    task automatic glitch(input int len, output int rel, output int pll_at, output int loss_at);
        int n0;
        n0      = cyc;
        lock_in = 1'b0;
        rel     = -1;
        pll_at  = -1;
        loss_at = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == len) lock_in = 1'b1;
            if (sys_rst_out && rel < 0) begin
                rel     = cyc - n0;
                pll_at  = int'(pll_rst_out);
                loss_at = int'(loss_cnt);
            end
        end
        lock_in = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_sys_rst"}, int'(sys_rst_out), 1);
        check({tag, "_pll_rst"}, int'(pll_rst_out), 1);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_loss"}, int'(loss_cnt), 0);
        check({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    initial begin
        int er, n, tr, es, t, rel, pll_at, loss_at, r1, r2, fall, ret1, k;
        logic prev;

        rst = 1'b1; lock_in = 1'b1; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        er  = cyc;
        rst = 1'b0;
        n = 0;
        while (pll_rst_out === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("pll_rst_width_after_reset", n, PLLRST);
        wait_state(2'd3, 200, tr);
        check("ready_rise_after_reset", tr - er, 25);
        check("first_lock_loss", int'(loss_cnt), 0);
        check("first_lock_retry", int'(retry_cnt), 0);

        glitch(3, rel, pll_at, loss_at);
        check("glitch3_no_reset", rel, -1);
        check("glitch3_ready", int'(ready), 1);
        check("glitch3_loss", int'(loss_cnt), 0);

        glitch(4, rel, pll_at, loss_at);
        check("glitch4_sys_rst_delay", rel, 6);
        check("glitch4_pll_rst", pll_at, 1);
        check("glitch4_loss", loss_at, 1);

        wait_state(2'd2, 50, es);
        repeat (10) @(negedge clk);
        lock_in = 1'b0;
        @(negedge clk);
        lock_in = 1'b1;
        t = cyc + 1;
        repeat (2) @(negedge clk);
        check("chatter_back_to_wait", int'(state), 1);
        wait_state(2'd3, 100, tr);
        check("chatter_ready_delay", tr - t, 18);

        n = cyc;
        lock_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (cyc == n + 5) clr_cnt = 1'b1;
            if (cyc == n + 6) begin
                clr_cnt = 1'b0;
                check("clr_vs_loss_loss", int'(loss_cnt), 0);
                check("clr_vs_loss_sys_rst", int'(sys_rst_out), 1);
            end
        end
        clr_cnt = 1'b0;
        lock_in = 1'b1;

        wait_state(2'd3, 100, tr);
        glitch(4, rel, pll_at, loss_at);
        check("loss_before_rst_run", loss_at, 1);
        wait_state(2'd3, 100, tr);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_in_run");

        lock_in = 1'b0;
        wait_state(2'd1, 50, t);
        repeat (20) @(negedge clk);
        check("still_waiting", int'(state), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_in_wait");

        er = cyc;
        prev = pll_rst_out;
        r1 = -1; r2 = -1; fall = -1; ret1 = -1;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (pll_rst_out && !prev) begin
                if (r1 < 0) begin
                    r1   = cyc;
                    ret1 = int'(retry_cnt);
                end else if (r2 < 0) begin
                    r2 = cyc;
                end
            end
            if (!pll_rst_out && prev && r1 >= 0 && fall < 0) fall = cyc;
            prev = pll_rst_out;
        end
        check("timeout_first_pulse", r1 - er, PLLRST + TIMEOUT);
        check("retry_period", r2 - r1, 108);
        check("retry_pulse_width", fall - r1, 8);
        check("retry_after_first", ret1, 1);

        k = 0;
        while (retry_cnt != 8'd255 && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check("retry_reaches_255", int'(retry_cnt), 255);
        repeat (45 * 108 + 20) @(negedge clk);
        check("retry_saturated", int'(retry_cnt), 255);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("retry_cleared", int'(retry_cnt), 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            if ($urandom_range(0, 1) == 1) begin
                lock_in = 1'b1;
                len = $urandom_range(1, 60);
            end else begin
                lock_in = 1'b0;
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 150) : $urandom_range(1, 6);
            end
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                clr_cnt = ($urandom_range(0, 49) == 0);
                rst     = ($urandom_range(0, 599) == 0);
            end
        end
        rst = 1'b0;
        clr_cnt = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
